// File: rtl/cpu_rst_seq.sv
// CPU reset sequencer: waits for a stable PLL lock, enables the CPU clock gate,
// holds the CPU in reset for a few cycles, then runs and watches for lock loss.
module cpu_rst_seq #(
   parameter int STABLE_CYC = 16,
   parameter int HOLD_CYC   = 4,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       soft_rst_req,
   output logic       cpu_clk_en,
   output logic       cpu_rst_n,
   output logic [1:0] state,
   output logic [7:0] lock_loss_cnt
);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_STABLE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             clk_en_d;
   logic             rst_n_d;
   logic [7:0]       loss_d;
   logic             sync_p0;
   logic             lock_s;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // locked is asynchronous to clk; only lock_s is used past this point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync_p0 <= locked;
         lock_s  <= sync_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_WAIT;
         cnt_q         <= '0;
         cpu_clk_en    <= 1'b0;
         cpu_rst_n     <= 1'b0;
         lock_loss_cnt <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cpu_clk_en    <= clk_en_d;
         cpu_rst_n     <= rst_n_d;
         lock_loss_cnt <= loss_d;
      end
   end

   assign state = state_q;

   // Outputs are registered copies of the next-state decision, never decoded from state_q
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clk_en_d = cpu_clk_en;
      rst_n_d  = cpu_rst_n;
      loss_d   = lock_loss_cnt;
      case (state_q)
         ST_WAIT: begin
            cnt_d    = '0;
            clk_en_d = 1'b0;
            rst_n_d  = 1'b0;
            if (lock_s) begin
               state_d = ST_STABLE;
            end
         end
         ST_STABLE: begin
            clk_en_d = 1'b0;
            rst_n_d  = 1'b0;
            if (!lock_s) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d  = ST_HOLD;
               cnt_d    = '0;
               clk_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!lock_s) begin
               state_d  = ST_WAIT;
               cnt_d    = '0;
               clk_en_d = 1'b0;
               rst_n_d  = 1'b0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               clk_en_d = 1'b1;
               rst_n_d  = 1'b1;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               clk_en_d = 1'b1;
               rst_n_d  = 1'b0;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            // Lock loss takes priority over a coincident soft reset request
            if (!lock_s) begin
               state_d  = ST_WAIT;
               clk_en_d = 1'b0;
               rst_n_d  = 1'b0;
               loss_d   = sat_inc(lock_loss_cnt);
            end else if (soft_rst_req) begin
               state_d  = ST_HOLD;
               clk_en_d = 1'b1;
               rst_n_d  = 1'b0;
            end else begin
               clk_en_d = 1'b1;
               rst_n_d  = 1'b1;
            end
         end
         default: begin
            state_d  = ST_WAIT;
            cnt_d    = '0;
            clk_en_d = 1'b0;
            rst_n_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_rst_seq.sv
// Bench for cpu_rst_seq: run-length reference model checked every cycle,
// plus literal checkpoints at the power-up, lock-loss and soft-reset milestones.
module tb_cpu_rst_seq;

   localparam int STABLE_CYC = 16;
   localparam int HOLD_CYC   = 4;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       soft_rst_req;
   logic       cpu_clk_en;
   logic       cpu_rst_n;
   logic [1:0] state;
   logic [7:0] lock_loss_cnt;

   cpu_rst_seq #(
      .STABLE_CYC(STABLE_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .CNT_W     (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .locked       (locked),
      .soft_rst_req (soft_rst_req),
      .cpu_clk_en   (cpu_clk_en),
      .cpu_rst_n    (cpu_rst_n),
      .state        (state),
      .lock_loss_cnt(lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the sequence position is the number of consecutive edges on which
   // the synchronized lock has been seen high; a soft reset overlays a HOLD window.
   typedef struct {
      logic s1;
      logic s2;
      int   run_len;
      int   soft_age;
      int   st;
      int   loss;
   } mdl_t;

   localparam mdl_t MDL_RST = '{1'b0, 1'b0, 0, -1, 0, 0};
   mdl_t mdl = MDL_RST;

   function automatic mdl_t mdl_step(input mdl_t m, input logic lk, input logic sr);
      mdl_t n;
      logic ls;
      int   prev;
      n    = m;
      ls   = m.s2;
      n.s2 = m.s1;
      n.s1 = lk;
      prev = m.st;
      if (!ls) begin
         if (prev == 3 && m.loss < 255) n.loss = m.loss + 1;
         n.run_len  = 0;
         n.soft_age = -1;
         n.st       = 0;
      end else begin
         n.run_len = m.run_len + 1;
         if (prev == 3 && sr) n.soft_age = 0;
         else if (m.soft_age >= 0) n.soft_age = m.soft_age + 1;
         if (n.run_len <= STABLE_CYC) n.st = 1;
         else if (n.run_len <= STABLE_CYC + HOLD_CYC) n.st = 2;
         else n.st = 3;
         if (n.soft_age >= HOLD_CYC) n.soft_age = -1;
         else if (n.soft_age >= 0) n.st = 2;
      end
      return n;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl = MDL_RST;
      else mdl = mdl_step(mdl, locked, soft_rst_req);
   end

   int    n_checks = 0;
   int    n_fail   = 0;
   int    pin_seq  = 0;
   int    pin_seen = 0;
   string pin_name = "";
   int    pin_st, pin_en, pin_rn, pin_ll;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      chk("model_state",  int'(state),          mdl.st);
      chk("model_clk_en", int'(cpu_clk_en),     int'(mdl.st >= 2));
      chk("model_rst_n",  int'(cpu_rst_n),      int'(mdl.st == 3));
      chk("model_loss",   int'(lock_loss_cnt),  mdl.loss);
      if (pin_seq != pin_seen) begin
         pin_seen = pin_seq;
         chk({pin_name, "_state"},  int'(state),         pin_st);
         chk({pin_name, "_clk_en"}, int'(cpu_clk_en),    pin_en);
         chk({pin_name, "_rst_n"},  int'(cpu_rst_n),     pin_rn);
         chk({pin_name, "_loss"},   int'(lock_loss_cnt), pin_ll);
      end
   end

   task automatic pin(input string nm, input int st, input int en, input int rn, input int ll);
      pin_name = nm;
      pin_st   = st;
      pin_en   = en;
      pin_rn   = rn;
      pin_ll   = ll;
      pin_seq++;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b1;
      locked       = 1'b1;
      soft_rst_req = 1'b0;
      #1 rst_n = 1'b0;

      // Reset held with lock present and clock running
      edges(5);
      pin("rst_hold", 0, 0, 0, 0);
      edges(3);
      pin("rst_hold_late", 0, 0, 0, 0);
      @(negedge clk);
      locked = 1'b0;
      rst_n  = 1'b1;
      edges(3);

      // Clean power-up
      @(negedge clk);
      locked = 1'b1;
      edges(1);
      edges(1);  pin("pu_k1", 0, 0, 0, 0);
      edges(1);  pin("pu_k2", 1, 0, 0, 0);
      edges(15); pin("pu_k17", 1, 0, 0, 0);
      edges(1);  pin("pu_k18", 2, 1, 0, 0);
      edges(3);  pin("pu_k21", 2, 1, 0, 0);
      edges(1);  pin("pu_k22", 3, 1, 1, 0);
      edges(5);

      // Lock loss in RUN, then relock
      @(negedge clk);
      locked = 1'b0;
      edges(1);
      edges(1);  pin("loss_m1", 3, 1, 1, 0);
      edges(1);  pin("loss_m2", 0, 0, 0, 1);
      edges(2);
      @(negedge clk);
      locked = 1'b1;
      edges(1);
      edges(21); pin("relock_k21", 2, 1, 0, 1);
      edges(1);  pin("relock_k22", 3, 1, 1, 1);
      edges(3);

      // Soft reset pulse, with a second pulse during HOLD that must be ignored
      @(negedge clk);
      soft_rst_req = 1'b1;
      edges(1);  pin("soft_e", 2, 1, 0, 1);
      @(negedge clk);
      soft_rst_req = 1'b0;
      edges(1);
      @(negedge clk);
      soft_rst_req = 1'b1;
      edges(1);
      @(negedge clk);
      soft_rst_req = 1'b0;
      edges(1);  pin("soft_e3", 2, 1, 0, 1);
      edges(1);  pin("soft_e4", 3, 1, 1, 1);
      edges(3);

      // Soft reset coincident with synchronized lock falling
      @(negedge clk);
      locked = 1'b0;
      edges(1);
      edges(1);
      @(negedge clk);
      soft_rst_req = 1'b1;
      edges(1);  pin("coinc", 0, 0, 0, 2);
      @(negedge clk);
      soft_rst_req = 1'b0;
      edges(2);

      // Glitchy lock: 10 high, 3 low, then high for good
      @(negedge clk);
      locked = 1'b1;
      edges(10);
      @(negedge clk);
      locked = 1'b0;
      edges(3);
      @(negedge clk);
      locked = 1'b1;
      edges(1);
      edges(17); pin("glitch_k17", 1, 0, 0, 2);
      edges(1);  pin("glitch_k18", 2, 1, 0, 2);
      edges(5);

      // Repeated lock loss from RUN until the counter saturates
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         locked = 1'b0;
         edges(3);
         @(negedge clk);
         locked = 1'b1;
         edges(23);
      end
      pin("sat", 3, 1, 1, 255);
      edges(1);

      // Asynchronous reset in the middle of HOLD
      @(negedge clk);
      locked = 1'b0;
      edges(3);
      @(negedge clk);
      locked = 1'b1;
      edges(1);
      edges(19); pin("pre_rst_hold", 2, 1, 0, 255);
      edges(1);
      rst_n = 1'b0;
      pin("rst_mid_hold", 0, 0, 0, 0);
      edges(2);
      @(negedge clk);
      rst_n = 1'b1;
      edges(1);
      edges(1);  pin("post_rst_k1", 0, 0, 0, 0);
      edges(21); pin("post_rst_k22", 3, 1, 1, 0);
      edges(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
